// File: rtl/gcd_pkg.sv
// Shared types for the GCD engine slice.
// State encoding and algorithm-select constants.
package gcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   localparam logic MODE_SUB = 1'b0;
   localparam logic MODE_BIN = 1'b1;

endpackage

// File: rtl/gcd_step.sv
// One GCD iteration: termination test or a single reduction.
// Pure combinational; the engine owns every register.
module gcd_step
   import gcd_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int K_W   = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [K_W-1:0]   k,
   input  logic             mode,
   output logic [WIDTH-1:0] a_nxt,
   output logic [WIDTH-1:0] b_nxt,
   output logic [K_W-1:0]   k_nxt,
   output logic             term,
   output logic [WIDTH-1:0] res
);

   always_comb begin
      a_nxt = a;
      b_nxt = b;
      k_nxt = k;
      term  = (a == '0) || (b == '0) || (a == b);
      // k only counts common factors of two, so the shift stays in range
      res   = (a == '0) ? (b << k) : (a << k);
      if (!term) begin
         if (mode == MODE_SUB) begin
            if (a > b) a_nxt = a - b;
            else       b_nxt = b - a;
         end else begin
            unique case ({a[0], b[0]})
               2'b00: begin
                  a_nxt = a >> 1;
                  b_nxt = b >> 1;
                  k_nxt = k + K_W'(1);
               end
               2'b01: a_nxt = a >> 1;
               2'b10: b_nxt = b >> 1;
               default: begin
                  if (a > b) a_nxt = a - b;
                  else       b_nxt = b - a;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/gcd_param_engine.sv
// Iterative GCD engine, subtractive or binary (Stein) per operation.
// valid/ready on both sides; one step per clock in CALC.
module gcd_param_engine
   import gcd_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = WIDTH + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             mode,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [CNT_W-1:0] iter,
   output logic             zero_in
);

   localparam int K_W = $clog2(WIDTH + 1);

   state_t           state;
   logic [WIDTH-1:0] a_q, b_q;
   logic [K_W-1:0]   k_q;
   logic             mode_q;

   logic [WIDTH-1:0] a_nxt, b_nxt, res;
   logic [K_W-1:0]   k_nxt;
   logic             term;

   gcd_step #(
      .WIDTH (WIDTH),
      .K_W   (K_W)
   ) u_step (
      .a     (a_q),
      .b     (b_q),
      .k     (k_q),
      .mode  (mode_q),
      .a_nxt (a_nxt),
      .b_nxt (b_nxt),
      .k_nxt (k_nxt),
      .term  (term),
      .res   (res)
   );

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         k_q     <= '0;
         mode_q  <= MODE_SUB;
         result  <= '0;
         iter    <= '0;
         zero_in <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= a_in;
                  b_q     <= b_in;
                  mode_q  <= mode;
                  k_q     <= '0;
                  iter    <= '0;
                  zero_in <= (a_in == '0) && (b_in == '0);
                  state   <= CALC;
               end
            end
            CALC: begin
               if (term) begin
                  result <= res;
                  state  <= DONE;
               end else begin
                  a_q <= a_nxt;
                  b_q <= b_nxt;
                  k_q <= k_nxt;
                  if (iter != '1) iter <= iter + CNT_W'(1);
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_param_engine.sv
// Directed bench for gcd_param_engine: vector table plus
// back-pressure, saturation and mid-operation reset sequences.
module tb_gcd_param_engine;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, mode, out_ready;
   logic [W-1:0] a_in, b_in;
   logic         in_ready, out_valid, zero_in;
   logic [W-1:0] result;
   logic [W:0]   iter;

   logic         iv2, or2;
   logic         in_ready2, out_valid2, zero_in2;
   logic [W-1:0] result2;
   logic [3:0]   iter2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   gcd_param_engine #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .a_in      (a_in),
      .b_in      (b_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .iter      (iter),
      .zero_in   (zero_in)
   );

   gcd_param_engine #(.WIDTH(W), .CNT_W(4)) dut_sat (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv2),
      .in_ready  (in_ready2),
      .mode      (mode),
      .a_in      (a_in),
      .b_in      (b_in),
      .out_valid (out_valid2),
      .out_ready (or2),
      .result    (result2),
      .iter      (iter2),
      .zero_in   (zero_in2)
   );

   typedef struct {
      logic         mode;
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           res;
      int           it;
      int           zi;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", name, act, exp);
      end
   endtask

   // Offer one pair, scramble inputs while busy, wait for out_valid.
   task automatic start_and_wait(input logic m, input logic [W-1:0] a,
                                 input logic [W-1:0] b, output int lat);
      @(negedge clk);
      in_valid = 1'b1;
      mode     = m;
      a_in     = a;
      b_in     = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      mode     = ~m;
      a_in     = 8'hA5;
      b_in     = 8'h3C;
      lat      = 1;
      while (!out_valid && lat < 600) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!out_valid) check("timeout", 0, 1);
   endtask

   task automatic handoff();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   initial begin
      int lat;
      vecs[0]  = '{1'b0, 8'd5,   8'd20,  5,   3,   0};
      vecs[1]  = '{1'b0, 8'd30,  8'd7,   1,   8,   0};
      vecs[2]  = '{1'b1, 8'd140, 8'd20,  20,  6,   0};
      vecs[3]  = '{1'b0, 8'd0,   8'd0,   0,   0,   1};
      vecs[4]  = '{1'b0, 8'd0,   8'd9,   9,   0,   0};
      vecs[5]  = '{1'b0, 8'd255, 8'd1,   1,   254, 0};
      vecs[6]  = '{1'b1, 8'd12,  8'd18,  6,   4,   0};
      vecs[7]  = '{1'b0, 8'd12,  8'd18,  6,   2,   0};
      vecs[8]  = '{1'b1, 8'd9,   8'd0,   9,   0,   0};
      vecs[9]  = '{1'b1, 8'd0,   8'd0,   0,   0,   1};
      vecs[10] = '{1'b1, 8'd255, 8'd255, 255, 0,   0};
      vecs[11] = '{1'b1, 8'd128, 8'd64,  64,  7,   0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      iv2       = 1'b0;
      or2       = 1'b0;
      mode      = 1'b0;
      a_in      = '0;
      b_in      = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_result", int'(result), 0);
      check("rst_iter", int'(iter), 0);
      check("rst_zero_in", int'(zero_in), 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         start_and_wait(vecs[i].mode, vecs[i].a, vecs[i].b, lat);
         check($sformatf("v%0d_result", i), int'(result), vecs[i].res);
         check($sformatf("v%0d_iter", i), int'(iter), vecs[i].it);
         check($sformatf("v%0d_zero_in", i), int'(zero_in), vecs[i].zi);
         check($sformatf("v%0d_latency", i), lat, vecs[i].it + 2);
         handoff();
         check($sformatf("v%0d_idle", i), int'(in_ready), 1);
      end

      // back-pressure: outputs frozen, no capture while DONE
      start_and_wait(1'b1, 8'd140, 8'd20, lat);
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         a_in     = 8'(i * 17);
         b_in     = 8'(i + 3);
         mode     = ~mode;
         @(posedge clk);
         #1;
         check("hold_in_ready", int'(in_ready), 0);
         check("hold_out_valid", int'(out_valid), 1);
         check("hold_result", int'(result), 20);
         check("hold_iter", int'(iter), 6);
      end
      in_valid = 1'b1;
      a_in     = 8'd3;
      b_in     = 8'd3;
      handoff();
      check("handoff_no_capture", int'(in_ready), 1);
      check("handoff_out_valid", int'(out_valid), 0);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("post_handoff_idle", int'(in_ready), 1);

      // saturating iteration counter on the CNT_W=4 build
      @(negedge clk);
      iv2  = 1'b1;
      mode = 1'b0;
      a_in = 8'd255;
      b_in = 8'd1;
      @(posedge clk);
      #1;
      iv2 = 1'b0;
      lat = 1;
      while (!out_valid2 && lat < 600) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("sat_out_valid", int'(out_valid2), 1);
      check("sat_iter", int'(iter2), 15);
      check("sat_result", int'(result2), 1);
      check("sat_latency", lat, 256);
      or2 = 1'b1;
      @(posedge clk);
      #1;
      or2 = 1'b0;
      check("sat_idle", int'(in_ready2), 1);

      // reset in the middle of a long operation
      @(negedge clk);
      in_valid = 1'b1;
      mode     = 1'b0;
      a_in     = 8'd255;
      b_in     = 8'd1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("pre_rst_busy", int'(in_ready), 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", int'(out_valid), 0);
      check("mid_rst_result", int'(result), 0);
      check("mid_rst_iter", int'(iter), 0);
      check("mid_rst_zero_in", int'(zero_in), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rel_in_ready", int'(in_ready), 1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("discarded_no_valid", int'(out_valid), 0);
      end
      start_and_wait(1'b1, 8'd12, 8'd18, lat);
      check("after_rst_result", int'(result), 6);
      check("after_rst_iter", int'(iter), 4);
      handoff();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gcd_param_engine.md
GCD_PARAM_ENGINE -- requirements
Module: gcd_param_engine

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width (legal range 2..32).
REQ-002 Parameter: CNT_W, default WIDTH+1, width of the iteration counter.
REQ-003 Port: clk  input  1  single clock, rising-edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: in_valid  input  1  operand pair offered.
REQ-006 Port: in_ready  output  1  engine can accept an operand pair.
REQ-007 Port: mode  input  1  0 = subtractive Euclid, 1 = binary (Stein); sampled with operands.
REQ-008 Port: a_in, b_in  input  WIDTH  unsigned operands.
REQ-009 Port: out_valid  output  1  result available.
REQ-010 Port: out_ready  input  1  consumer accepts result.
REQ-011 Port: result  output  WIDTH  gcd(a,b).
REQ-012 Port: iter  output  CNT_W  number of reduction steps taken, saturating.
REQ-013 Port: zero_in  output  1  both operands were zero (result 0).

Function
REQ-014 States SHALL be IDLE, CALC and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 IDLE, in_valid&&in_ready at an edge: capture a_in, b_in, mode; clear iter, shift count k and zero_in; go to CALC.
REQ-016 CALC SHALL perform exactly one termination check or one reduction step per clock edge.
REQ-017 Termination (both modes, checked first): a==0 -> result=b<<k; b==0 -> result=a<<k; a==b -> result=a<<k; go to DONE on that edge.
REQ-018 Subtractive step: a>b -> a=a-b, else b=b-a; k stays 0.
REQ-019 Binary step, in priority: both even -> a>>=1, b>>=1, k+=1; a even -> a>>=1; b even -> b>>=1; both odd -> larger -= smaller.
REQ-020 k SHALL be ceil(log2(WIDTH+1)) bits wide; the final shift SHALL NOT overflow WIDTH.
REQ-021 Each reduction step SHALL increment iter; iter saturates at all-ones and never wraps.
REQ-022 Latency SHALL be iter+2 edges from accept to out_valid high.
REQ-023 zero_in SHALL be set when both captured operands are 0; result is 0 in that case.
REQ-024 DONE SHALL hold result, iter and zero_in stable until out_valid&&out_ready, then return to IDLE.
REQ-025 No new operands SHALL be accepted in the same edge as result hand-off (one IDLE cycle minimum).
REQ-026 in_valid, mode, a_in and b_in SHALL be ignored outside IDLE; mode changes mid-operation have no effect.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, in_ready=1 after release, out_valid=0, result=0, iter=0, zero_in=0 and internal a, b, k to 0.
REQ-028 Reset asserted in CALC or DONE SHALL discard the operation; no out_valid is produced for it.

Structure
REQ-029 Package gcd_pkg SHALL hold the state enum (IDLE/CALC/DONE) and the mode constants MODE_SUB=0 and MODE_BIN=1.
REQ-030 One sub-module gcd_step SHALL be purely combinational: given a, b, k and mode, it returns the next a, b, k and the terminate flag; the parent holds all state registers.

Verification
REQ-031 Test 1: mode=0, a=5, b=20 -> result=5, iter=3, out_valid 5 edges after accept.
REQ-032 Test 2: mode=0, a=30, b=7 -> result=1, iter=8; then mode=1, a=140, b=20 -> result=20, iter=6.
REQ-033 Test 3: a=0, b=0 -> result=0, zero_in=1, iter=0; then a=0, b=9 -> result=9, zero_in=0, iter=0 (latency 2).
REQ-034 Test 4: hold out_ready=0 for 10 cycles after out_valid -> outputs stable and in_ready=0 throughout; toggle in_valid meanwhile -> no capture.
REQ-035 Test 5: WIDTH=8, mode=0, a=255, b=1 -> iter=254 (no saturation); CNT_W=4 build -> iter=15 saturated, result=1.
REQ-036 Test 6: assert rst_n mid-CALC -> outputs zero immediately, in_ready=1 after release, and a following gcd(12,18) in mode=1 -> result=6.
